// File: rtl/c_lock_rr_arbiter.sv
// ----------------------------------------------------------------------------
// c_lock_rr_arbiter
//
// Round-robin arbiter with per-requester lock. A granted port can keep its
// grant for consecutive cycles while it holds both req and lock, optionally
// bounded by max_hold cycles. On release the arbiter re-arbitrates
// immediately from the already-advanced priority pointer, so there is no idle
// cycle between owners. A sticky integrity monitor flags a multi-hot grant
// register or a gnt_valid/state disagreement.
//
// Parameters
//   num_ports : number of requesters (2..32)
//   max_hold  : max consecutive grant cycles per lock, 0 = unlimited
//
// Ports
//   clk       : clock
//   reset     : synchronous, active-high reset
//   active    : enable; when low every register holds its value
//   req       : [0:num_ports-1] per-port request
//   lock      : [0:num_ports-1] per-port request to keep the current grant
//   gnt       : [0:num_ports-1] registered one-hot grant (or all zeros)
//   gnt_valid : registered OR of gnt
//   error     : sticky integrity error, cleared only by reset
// ----------------------------------------------------------------------------
module c_lock_rr_arbiter #(
  parameter int num_ports = 4,
  parameter int max_hold  = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 active,
  input  logic [0:num_ports-1] req,
  input  logic [0:num_ports-1] lock,
  output logic [0:num_ports-1] gnt,
  output logic                 gnt_valid,
  output logic                 error
);

  localparam int ptr_w = $clog2(num_ports);
  // With max_hold = 0 the counter is unused but still needs a legal width.
  localparam int cnt_w = (max_hold == 0) ? 1 : $clog2(max_hold + 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [ptr_w-1:0]     ptr_q, ptr_d;
  logic [ptr_w-1:0]     owner_q, owner_d;
  logic [cnt_w-1:0]     cnt_q, cnt_d;
  logic [0:num_ports-1] gnt_q, gnt_d;
  logic                 gnt_valid_q, gnt_valid_d;
  logic                 error_q, error_d;

  // --------------------------------------------------------------------------
  // Round-robin pick: port ptr_q has top priority, priority falls with index
  // modulo num_ports. The loop walks from lowest to highest priority so the
  // last hit is the winner.
  // --------------------------------------------------------------------------
  logic             pick_valid;
  logic [ptr_w-1:0] pick_idx;
  logic [ptr_w-1:0] pick_next_ptr;

  always_comb begin : arb
    int idx;
    // NOTE: every variable assigned here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    idx        = 0;
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = num_ports - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % num_ports;
      if (req[idx]) begin
        pick_valid = 1'b1;
        pick_idx   = ptr_w'(idx);
      end
    end
    pick_next_ptr = ptr_w'((int'(pick_idx) + 1) % num_ports);
  end

  // --------------------------------------------------------------------------
  // Integrity monitor inputs
  // --------------------------------------------------------------------------
  logic [0:num_ports-1] gnt_minus_one;
  logic                 gnt_multi_hot;
  logic                 valid_mismatch;
  logic                 hold_limit;
  logic                 keep_grant;

  always_comb begin
    // Clearing the lowest set bit leaves something only if two or more bits
    // were set.
    gnt_minus_one  = gnt_q - {{(num_ports - 1){1'b0}}, 1'b1};
    gnt_multi_hot  = |(gnt_q & gnt_minus_one);
    valid_mismatch = (state_q == IDLE) ? gnt_valid_q : !gnt_valid_q;
    hold_limit     = (max_hold != 0) && (cnt_q == cnt_w'(max_hold));
    // Only the owner's lock matters; lock bits of other ports are ignored.
    keep_grant     = req[owner_q] && lock[owner_q] && !hold_limit;
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    error_d = error_q;

    if (active) begin
      error_d = error_q || gnt_multi_hot || valid_mismatch;

      if (state_q == BUSY && keep_grant) begin
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      end else if (pick_valid) begin
        // Fresh arbitration from IDLE, or a release with requests pending:
        // grant at the next edge with no idle cycle in between.
        state_d         = BUSY;
        gnt_d           = '0;
        gnt_d[pick_idx] = 1'b1;
        owner_d         = pick_idx;
        ptr_d           = pick_next_ptr;
        cnt_d           = cnt_w'(1);
      end else if (state_q == BUSY) begin
        state_d = IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    end

    gnt_valid_d = |gnt_d;
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge value of the others, independent of statement order.
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      error_q     <= error_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign error     = error_q;

endmodule

// File: tb/tb_c_lock_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_c_lock_rr_arbiter
//
// Two arbiter instances: u_dut (num_ports=4, max_hold=3) and u_dut0
// (num_ports=4, max_hold=0). Expected grants are queued when stimulus is
// applied and popped/compared one cycle later, after the sampling edge.
// Vectors are written port 0 first (gnt=1000 means port 0 granted).
// ----------------------------------------------------------------------------
module tb_c_lock_rr_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       active;
  logic [0:3] req_a, lock_a, gnt_a;
  logic [0:3] req_b, lock_b, gnt_b;
  logic       gv_a, err_a, gv_b, err_b;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    string      tag;
    bit         sel;   // 0: u_dut, 1: u_dut0
    logic [0:3] gnt;
    logic       gv;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  c_lock_rr_arbiter #(.num_ports(4), .max_hold(3)) u_dut (
    .clk(clk), .reset(reset), .active(active),
    .req(req_a), .lock(lock_a),
    .gnt(gnt_a), .gnt_valid(gv_a), .error(err_a)
  );

  c_lock_rr_arbiter #(.num_ports(4), .max_hold(0)) u_dut0 (
    .clk(clk), .reset(reset), .active(active),
    .req(req_b), .lock(lock_b),
    .gnt(gnt_b), .gnt_valid(gv_b), .error(err_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Apply one cycle of stimulus, queue the grant it must produce, then pop
  // and compare once the edge has happened.
  task automatic step(input string tag, input bit sel, input logic [0:3] r,
                      input logic [0:3] l, input logic [0:3] eg);
    exp_t e, o;
    if (sel) begin req_b = r; lock_b = l; end
    else     begin req_a = r; lock_a = l; end
    e.tag = tag; e.sel = sel; e.gnt = eg; e.gv = |eg;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      o = sb_q.pop_front();
      check({o.tag, "_gnt"}, 32'(o.sel ? gnt_b : gnt_a), 32'(o.gnt));
      check({o.tag, "_gv"},  32'(o.sel ? gv_b : gv_a),   32'(o.gv));
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset  = 1'b1;
    active = 1'b1;
    req_a  = '0; lock_a = '0;
    req_b  = '0; lock_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", 32'(gnt_a), 32'd0);
    check("rst_gv",  32'(gv_a),  32'd0);
    check("rst_err", 32'(err_a), 32'd0);
    reset = 1'b0;

    // Plain round robin, no locks: single-cycle grants rotating from port 0.
    step("rr0", 0, 4'b1111, 4'b0000, 4'b1000);
    step("rr1", 0, 4'b1111, 4'b0000, 4'b0100);
    step("rr2", 0, 4'b1111, 4'b0000, 4'b0010);
    step("rr3", 0, 4'b1111, 4'b0000, 4'b0001);
    step("rr4", 0, 4'b1111, 4'b0000, 4'b1000);
    step("rr_idle", 0, 4'b0000, 4'b0000, 4'b0000);

    // Locked port 1 held for max_hold cycles, one turn for port 2, back to 1.
    pulse_reset();
    step("lk0", 0, 4'b0110, 4'b0100, 4'b0100);
    step("lk1", 0, 4'b0110, 4'b0100, 4'b0100);
    step("lk2", 0, 4'b0110, 4'b0100, 4'b0100);
    step("lk3", 0, 4'b0110, 4'b0100, 4'b0010);
    step("lk4", 0, 4'b0110, 4'b0100, 4'b0100);
    step("lk5", 0, 4'b0110, 4'b0100, 4'b0100);
    step("lk_idle", 0, 4'b0000, 4'b0000, 4'b0000);

    // Freeze with active=0 on a port-2 grant; inputs that would release it
    // are applied during the freeze and must be ignored.
    pulse_reset();
    step("fz_gnt", 0, 4'b0010, 4'b0010, 4'b0010);
    check("fz_cnt_start", 32'(u_dut.cnt_q), 32'd1);
    active = 1'b0;
    for (int i = 0; i < 4; i++) step("fz_hold", 0, 4'b0000, 4'b0000, 4'b0010);
    check("fz_cnt", 32'(u_dut.cnt_q), 32'd1);
    check("fz_ptr", 32'(u_dut.ptr_q), 32'd3);
    active = 1'b1;
    step("fz_run1", 0, 4'b0010, 4'b0010, 4'b0010);
    check("fz_cnt2", 32'(u_dut.cnt_q), 32'd2);
    step("fz_run2", 0, 4'b0010, 4'b0010, 4'b0010);
    check("fz_cnt3", 32'(u_dut.cnt_q), 32'd3);
    // Hold limit reached with port 2 the sole requester: regranted, count 1.
    step("fz_regrant", 0, 4'b0010, 4'b0010, 4'b0010);
    check("fz_cnt_reload", 32'(u_dut.cnt_q), 32'd1);

    // Reset mid-grant drops gnt at that edge; arbitration restarts at port 0.
    req_a  = 4'b1111;
    lock_a = 4'b0000;
    reset  = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("mid_rst_gnt", 32'(gnt_a), 32'd0);
    check("mid_rst_err", 32'(err_a), 32'd0);
    step("post_rst", 0, 4'b1111, 4'b0000, 4'b1000);
    step("post_rst_idle", 0, 4'b0000, 4'b0000, 4'b0000);
    check("pre_force_err", 32'(err_a), 32'd0);

    // Corrupt the grant register to multi-hot: error sets and sticks.
    force u_dut.gnt_q = 4'b1100;
    @(posedge clk);
    #1;
    release u_dut.gnt_q;
    check("mh_err", 32'(err_a), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("mh_sticky", 32'(err_a), 32'd1);
    end
    pulse_reset();
    check("mh_rst_clear", 32'(err_a), 32'd0);

    // Unlimited hold (max_hold=0): lock keeps port 3 indefinitely.
    for (int i = 0; i < 10; i++) step("unl", 1, 4'b0001, 4'b0001, 4'b0001);
    step("unl_drop", 1, 4'b0000, 4'b0000, 4'b0000);
    check("unl_state_idle", 32'(u_dut0.state_q), 32'd0);
    check("unl_err", 32'(err_b), 32'd0);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
